// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared constants and types for the pixel loader and its downstream stages
package pixel_pkg;

  localparam int NPIX   = 9;
  localparam int DATA_W = 20;
  localparam int IDX_W  = $clog2(NPIX);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } loader_state_e;

endpackage

// File: rtl/pixel_frame_loader.sv
// rtl/pixel_frame_loader.sv - double-buffered serial-to-frame pixel assembler
// Optional pix_last framing check enabled by LOADER_FRAMECHK_EN.
module pixel_frame_loader
  import pixel_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic             pix_data,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic [NPIX-1:0]  frame_x,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err,
  input  logic             err_clr
);

  loader_state_e    state_q;
  logic [IDX_W-1:0] idx_q;
  logic [NPIX-1:0]  asm_q;
  logic [NPIX-1:0]  asm_d;
  logic [NPIX-1:0]  frame_q;
  logic             fvalid_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic consume;
  logic buf_free;
  logic last_pix;
  logic frame_err;

  assign pix_ready = !rst && (state_q == COLLECT);
  assign accept    = pix_valid && pix_ready;
  assign consume   = fvalid_q && frame_ready;
  assign buf_free  = !fvalid_q || frame_ready;
  assign last_pix  = (idx_q == IDX_W'(NPIX - 1));

  // Assembly register including the pixel on the input this cycle, so a
  // completing frame can move to the output buffer at the same edge.
  always_comb begin
    asm_d        = asm_q;
    asm_d[idx_q] = pix_data;
  end

`ifdef LOADER_FRAMECHK_EN
  logic err_q;

  assign frame_err = accept && (pix_last != last_pix);
  assign err       = err_q;

  // A new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (frame_err) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end
`else
  logic unused_inputs;

  assign frame_err     = 1'b0;
  assign err           = 1'b0;
  assign unused_inputs = ^{pix_last, err_clr};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      idx_q    <= '0;
      asm_q    <= '0;
      frame_q  <= '0;
      fvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (consume) begin
        fvalid_q <= 1'b0;
      end
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (frame_err) begin
              idx_q <= '0;
              asm_q <= '0;
            end else if (last_pix) begin
              idx_q <= '0;
              if (buf_free) begin
                frame_q  <= asm_d;
                fvalid_q <= 1'b1;
                cnt_q    <= cnt_q + CNT_W'(1);
                asm_q    <= '0;
              end else begin
                asm_q   <= asm_d;
                state_q <= FULL;
              end
            end else begin
              asm_q <= asm_d;
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        FULL: begin
          // Held frame moves up as the output buffer is consumed.
          if (consume) begin
            frame_q  <= asm_q;
            fvalid_q <= 1'b1;
            cnt_q    <= cnt_q + CNT_W'(1);
            asm_q    <= '0;
            idx_q    <= '0;
            state_q  <= COLLECT;
          end
        end
      endcase
    end
  end

  assign frame_x     = frame_q;
  assign frame_valid = fvalid_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
Upstream feeder for the 3x3 weighted-sum stage and its sibling classifier stages. Accepts a serial stream of binary pixels over a valid/ready handshake and assembles them into 9-pixel frames. Presents each completed frame as a stable 9-bit vector under a frame_valid/frame_ready handshake. Double-buffered, so the next frame can be collected while the current one is being consumed.

Parameters:
NPIX, 9, pixels per frame; bit i of frame_x drives X_i of the downstream stage.
CNT_W, 16, width of the completed-frame counter.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
pix_valid  in  1  upstream pixel valid
pix_data  in  1  pixel value, 0 or 1
pix_last  in  1  marks the final pixel of a frame
pix_ready  out  1  loader can accept a pixel
frame_x  out  NPIX  assembled frame; bit i = pixel i in arrival order
frame_valid  out  1  frame_x holds an unconsumed frame
frame_ready  in  1  downstream consumes frame this cycle
frame_cnt  out  CNT_W  frames delivered to the output buffer since reset
err  out  1  sticky framing error
err_clr  in  1  clears err

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - frame_x=0, frame_valid=0, frame_cnt=0, err=0.
  - Assembly register=0, index=0, state=COLLECT.
  - pix_ready=0 while rst=1.
- State machine:
  - COLLECT: pix_ready=1. A pixel is accepted on a cycle with pix_valid&&pix_ready. It is written to asm[idx], then idx increments.
  - Accepting pixel idx=NPIX-1 completes the frame.
    - If the output buffer is free this cycle (frame_valid=0, or frame_valid&&frame_ready), the frame (including the final bit) moves to frame_x at that edge. frame_valid=1 next cycle, idx=0, stay in COLLECT.
    - Otherwise go to FULL.
  - FULL: pix_ready=0. On a cycle with frame_valid&&frame_ready, the assembly register moves to frame_x at that edge. frame_valid stays 1, idx=0, return to COLLECT.
- Latency: the last pixel accepted at edge N gives frame_valid visible after edge N. Zero bubbles when downstream is always ready. Sustained throughput is 1 pixel/cycle.
- Output handshake:
  - frame_x and frame_valid are held stable while frame_valid&&!frame_ready.
  - frame_valid drops after a consume edge unless a new frame transfers at the same edge.
- frame_cnt increments by 1 on every transfer into frame_x. It wraps from 2^CNT_W-1 to 0.
- Simultaneous pix accept and frame consume in COLLECT: both happen. A completing frame transfers in the same edge.
- Reset mid-frame: any partial frame is discarded and all state returns to reset values.
- pix_data values other than 0/1 cannot occur (1-bit port).

Optional Feature:
Macro: LOADER_FRAMECHK_EN.
- Defined:
  - pix_last is checked on every accepted pixel.
  - pix_last=1 at idx<NPIX-1, or pix_last=0 at idx=NPIX-1, is a framing error. The partial frame is discarded (no transfer, frame_cnt unchanged), idx=0, state=COLLECT, err set.
  - err_clr clears err at the next edge. If err_clr and a new error occur in the same cycle, err stays 1.
- Not defined:
  - pix_last is ignored. Frames are delimited purely by counting NPIX pixels.
  - err is tied to 0 and err_clr is ignored.
- Port list is identical in both builds.

Decomposition:
- Shared package pixel_pkg holds:
  - NPIX=9.
  - The fixed-point data width of 20 shared with the weight/bias datapath.
  - The loader state enum {COLLECT, FULL}.
  - The index width derived from NPIX via clog2.
- No sub-module. The assembly register, output buffer and FSM are one module of roughly 150 lines.

Test Plan:
- Reset/idle: hold rst=1 for 3 cycles, then release → frame_valid=0, frame_x=0, frame_cnt=0, err=0; pix_ready=0 during reset and 1 from the first cycle after.
- Single frame: stream bits 1,0,1,0,1,0,1,0,1 back-to-back with pix_last on the 9th, frame_ready=1 → frame_x=9'b101010101 with frame_valid=1 the cycle after the 9th accept; frame_cnt=1.
- Backpressure: frame_ready=0 and stream two frames (all ones, then 0x0F0) → after frame 2 completes, pix_ready=0 (FULL) and frame_x stays 0x1FF. Raising frame_ready gives 0x1FF consumed, then 0x0F0 presented the next cycle; frame_cnt=2.
- Continuous streaming: 20 frames, 1 pixel/cycle, frame_ready=1 → exactly one frame_valid pulse per 9 cycles, no stalls; frame_cnt=20.
- Framing error (LOADER_FRAMECHK_EN): pix_last on the 5th pixel → err=1 and no frame output. A following well-formed frame 0x155 is delivered correctly; err_clr then clears err.
- Mid-frame reset: pulse rst after 4 pixels, then send a full frame 0x1AA → only 0x1AA appears; frame_cnt=1.
